counter_scheduler: RTL and testbench

//  Time-shares one external 8-bit up counter among N_REQ requesters.
//  - Each requester asks for an interval of len[i] counter increments.
//  - A round-robin arbiter picks one requester at a time.
//  - The controller drives the counter's sync clear and enable, watches its

---
 rtl/counter_scheduler_pkg.sv | 20 ++
 rtl/counter_scheduler_rr_arbiter.sv | 40 ++++
 rtl/counter_scheduler.sv | 119 +++++++++++
 tb/tb_counter_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// counter_scheduler_pkg: shared state encoding and counter width default.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package counter_scheduler_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/counter_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick of the first request at or after
// the pointer, with wrap-around. Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  int j;

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
        vld_o    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_scheduler.sv
// ----------------------------------------------------------------------------
// counter_scheduler: time-shares one external up counter among N_REQ
// requesters using round-robin arbitration. Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*CNT_W-1:0] len_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o,
  output logic                   cnt_clr_o,
  output logic                   cnt_en_o,
  input  logic [CNT_W-1:0]       cnt_val_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   owner_oh_q, owner_oh_d;
  logic [CNT_W-1:0]   len_q, len_d;

  logic [N_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               owner_req;
  logic [IDX_W-1:0]   owner_nxt;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  assign owner_req = |(req_i & owner_oh_q);
  assign owner_nxt = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_oh_d = owner_oh_q;
    len_d      = len_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d    = ST_LOAD;
          owner_d    = pick_idx;
          owner_oh_d = pick_oh;
          len_d      = len_i[int'(pick_idx)*CNT_W +: CNT_W];
        end
      end
      ST_LOAD: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
          ptr_d   = owner_nxt;
        end else if (len_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // The counter reaches len_q on the edge that leaves RUN.
        if (!owner_req) begin
          state_d = ST_IDLE;
          ptr_d   = owner_nxt;
        end else if (cnt_val_i == len_q - CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = owner_nxt;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      owner_oh_q <= '0;
      len_q      <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_oh_q <= owner_oh_d;
      len_q      <= len_d;
      ptr_q      <= ptr_d;
    end
  end

  assign grant_o   = (state_q == ST_LOAD || state_q == ST_RUN) ? owner_oh_q : '0;
  assign done_o    = (state_q == ST_DONE) ? owner_oh_q : '0;
  assign busy_o    = (state_q != ST_IDLE);
  assign cnt_clr_o = (state_q == ST_LOAD);
  assign cnt_en_o  = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_counter_scheduler.sv
// ----------------------------------------------------------------------------
// tb_counter_scheduler: scoreboard bench with a job-level reference model and
// an 8-bit up counter attached to the scheduler. Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_counter_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] len_bus = '0;
  logic [N-1:0]   grant, done;
  logic           busy, cnt_clr, cnt_en;
  logic [W-1:0]   cnt_val = '0;

  counter_scheduler #(.N_REQ(N), .CNT_W(W)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .len_i     (len_bus),
    .grant_o   (grant),
    .done_o    (done),
    .busy_o    (busy),
    .cnt_clr_o (cnt_clr),
    .cnt_en_o  (cnt_en),
    .cnt_val_i (cnt_val)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_clr)     cnt_val <= '0;
    else if (cnt_en) cnt_val <= cnt_val + 1'b1;
  end

  typedef struct {
    int owner;
    int cyc;
    bit dn;
    int len;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   tmo_cnt = 0;
  int   tmo_seen = 0;
  bit   end_req = 1'b0;
  bit   end_ack = 1'b0;

  // Monitor / checker
  bit         ep_active = 1'b0;
  int         ep_owner, ep_cyc, ep_en;
  logic [N-1:0] prev_grant = '0;

  always begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      #1;
      n_checks++;
      if (grant != '0 || done != '0 || busy || cnt_en || cnt_clr) begin
        n_errors++;
        $display("FAIL reset_outputs: grant=%b done=%b busy=%b en=%b clr=%b, required all zero",
                 grant, done, busy, cnt_en, cnt_clr);
      end
      ep_active  = 1'b0;
      prev_grant = '0;
    end else begin
      if (tmo_cnt != tmo_seen) begin
        n_checks++;
        n_errors++;
        $display("FAIL timeout: batch did not complete, timeouts=%0d required 0", tmo_cnt);
        tmo_seen = tmo_cnt;
      end
      n_checks++;
      if (busy !== ((grant != '0) || (done != '0))) begin
        n_errors++;
        $display("FAIL busy: busy=%b grant=%b done=%b", busy, grant, done);
      end
      if (grant != '0) begin
        if (!ep_active) begin
          ep_active = 1'b1;
          ep_cyc    = 0;
          ep_en     = 0;
          ep_owner  = -1;
          for (int i = 0; i < N; i++) if (grant[i]) ep_owner = i;
          n_checks++;
          if (!$onehot(grant)) begin
            n_errors++;
            $display("FAIL grant_onehot: grant=%b required one-hot", grant);
          end
        end else if (grant != prev_grant) begin
          n_checks++;
          n_errors++;
          $display("FAIL grant_stable: grant=%b required %b", grant, prev_grant);
        end
        ep_cyc++;
        if (cnt_en) ep_en++;
      end else if (ep_active) begin
        ep_active = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_grant: owner=%0d cycles=%0d with empty scoreboard", ep_owner, ep_cyc);
        end else begin
          exp_t e;
          logic [N-1:0] want_done;
          e = exp_q.pop_front();
          want_done = e.dn ? (N'(1) << e.owner) : '0;
          if (ep_owner != e.owner || ep_cyc != e.cyc || done != want_done) begin
            n_errors++;
            $display("FAIL job: owner=%0d cycles=%0d done=%b, required owner=%0d cycles=%0d done=%b",
                     ep_owner, ep_cyc, done, e.owner, e.cyc, want_done);
          end
          if (e.dn) begin
            n_checks++;
            if (int'(cnt_val) != e.len || ep_en != e.len) begin
              n_errors++;
              $display("FAIL count: cnt_val=%0d en_cycles=%0d, required %0d and %0d",
                       cnt_val, ep_en, e.len, e.len);
            end
          end
        end
      end else begin
        if (done != '0 || cnt_en) begin
          n_checks++;
          n_errors++;
          $display("FAIL stray_output: done=%b cnt_en=%b while no grant episode", done, cnt_en);
        end
      end
      prev_grant = grant;
      if (end_req && !end_ack) begin
        n_checks++;
        if (exp_q.size() != 0) begin
          n_errors++;
          $display("FAIL leftover: %0d expected jobs never seen, required 0", exp_q.size());
        end
        end_ack = 1'b1;
      end
    end
  end

  // Reference model: all requests in a batch are raised together while idle,
  // so each is served once in round-robin order starting at the pointer.
  int m_ptr = 0;
  int b_len[N];
  int b_ab[N];

  function automatic void clear_cfg();
    for (int i = 0; i < N; i++) begin
      b_len[i] = 0;
      b_ab[i]  = 0;
    end
  endfunction

  task automatic run_batch(input logic [N-1:0] set);
    int           cyc[N];
    logic [N-1:0] fin;
    int           last;
    exp_t         e;
    last = m_ptr;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (set[i]) begin
        e.owner = i;
        e.len   = b_len[i];
        e.dn    = (b_ab[i] == 0);
        e.cyc   = e.dn ? b_len[i] + 1 : b_ab[i];
        exp_q.push_back(e);
        last = i;
      end
    end
    m_ptr = (last + 1) % N;
    for (int i = 0; i < N; i++) begin
      len_bus[i*W +: W] = W'(b_len[i]);
      cyc[i] = 0;
    end
    req = set;
    fin = ~set;
    for (int t = 0; t < N * 262 + 50 && fin != '1; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!fin[i]) begin
          if (done[i]) begin
            req[i] = 1'b0;
            fin[i] = 1'b1;
          end else if (grant[i]) begin
            cyc[i]++;
            if (cyc[i] == 1) len_bus[i*W +: W] = W'($urandom);
            if (b_ab[i] != 0 && cyc[i] == b_ab[i]) begin
              req[i] = 1'b0;
              fin[i] = 1'b1;
            end
          end
        end
      end
    end
    if (fin != '1) begin
      tmo_cnt++;
      req = '0;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    repeat (2) @(negedge clk);

    clear_cfg(); b_len[0] = 3;
    run_batch(4'b0001);
    clear_cfg(); for (int i = 0; i < N; i++) b_len[i] = 1;
    run_batch(4'b1111);
    clear_cfg(); b_len[2] = 0;
    run_batch(4'b0100);
    clear_cfg(); b_len[0] = 10; b_ab[0] = 5; b_len[1] = 2;
    run_batch(4'b0011);

    // Asynchronous reset in the middle of a run
    req = 4'b0001;
    len_bus[W-1:0] = 8'd10;
    for (int t = 0; t < 50 && !grant[0]; t++) @(negedge clk);
    if (!grant[0]) tmo_cnt++;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    clear_cfg(); b_len[1] = 2;
    run_batch(4'b0010);

    clear_cfg(); b_len[0] = 255;
    run_batch(4'b0001);

    for (int r = 0; r < 25; r++) begin
      clear_cfg();
      for (int i = 0; i < N; i++) begin
        b_len[i] = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 12));
        if (b_len[i] > 0 && $urandom_range(0, 3) == 0) b_ab[i] = int'($urandom_range(1, b_len[i]));
      end
      run_batch(N'($urandom_range(1, 15)));
    end

    end_req = 1'b1;
    for (int t = 0; t < 10 && !end_ack; t++) @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
